// File: rtl/ppe_pkg.sv
// ppe_pkg: shared constants and types for the PPE sequencer slice.
//   - Opcode values carried on the inbound/outbound packet opcode field.
//   - Sequencer FSM state encoding.
//   - Bit offsets of the fields inside the 25-bit packet payload.
package ppe_pkg;

  localparam logic [3:0] OP_WLOAD = 4'h1;
  localparam logic [3:0] OP_ILOAD = 4'h2;
  localparam logic [3:0] OP_START = 4'h3;
  localparam logic [3:0] OP_PSUM  = 4'h4;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StSend
  } state_e;

  // WLOAD payload: {unused, weight[10:3], addr[2:0]}
  localparam int unsigned WL_ADDR_LSB = 0;
  localparam int unsigned WL_ADDR_W   = 3;
  localparam int unsigned WL_DATA_LSB = 3;

  // PSUM payload: {pos[24:20], 9'b0, psum[10:0]}
  localparam int unsigned PKT_W       = 25;
  localparam int unsigned OUT_POS_LSB = 20;
  localparam int unsigned OUT_POS_W   = 5;

endpackage

// File: rtl/ppe_mac_acc.sv
// ppe_mac_acc: registered spike-gated accumulator.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - zero the accumulator (wins over en)
//   en        - accumulate this cycle
//   spike     - gate: weight is added only when set
//   weight    - unsigned weight operand
//   acc       - current accumulated value
module ppe_mac_acc #(
  parameter int unsigned WEIGHT_W = 8,
  parameter int unsigned PSUM_W   = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                en,
  input  logic                spike,
  input  logic [WEIGHT_W-1:0] weight,
  output logic [PSUM_W-1:0]   acc
);

  logic [PSUM_W-1:0] acc_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_q <= '0;
    end else if (en && spike) begin
      acc_q <= acc_q + PSUM_W'(weight);
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/ppe_sequencer.sv
// ppe_sequencer: sequences one PPE's weight RF and input RF and computes a
// 1-D spike-gated convolution row, emitting one PSUM packet per position.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   in_valid/in_ready          - inbound packet handshake
//   in_opcode, in_data         - inbound opcode and 25-bit payload
//   w_we/w_waddr/w_wdata       - weight RF write port (pulse after accept)
//   w_raddr, w_rdata           - weight RF read port (data one cycle later)
//   i_we/i_wdata               - input RF whole-vector write
//   i_raddr, i_rdata           - input RF spike read (data one cycle later)
//   out_valid/out_ready        - outbound packet handshake
//   out_dest/out_opcode/out_data - outbound packet fields
//   busy                       - any state other than idle
//   err                        - one-cycle pulse on a rejected command
module ppe_sequencer
  import ppe_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 25,
  parameter int unsigned FILTER     = 5,
  parameter int unsigned WEIGHT_W   = 8,
  parameter int unsigned PSUM_W     = 11,
  parameter logic [3:0]  OUT_DEST   = 4'hA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_opcode,
  input  logic [PKT_W-1:0]      in_data,
  output logic                  w_we,
  output logic [2:0]            w_waddr,
  output logic [WEIGHT_W-1:0]   w_wdata,
  output logic [2:0]            w_raddr,
  input  logic [WEIGHT_W-1:0]   w_rdata,
  output logic                  i_we,
  output logic [NUM_INPUTS-1:0] i_wdata,
  output logic [4:0]            i_raddr,
  input  logic                  i_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_dest,
  output logic [3:0]            out_opcode,
  output logic [PKT_W-1:0]      out_data,
  output logic                  busy,
  output logic                  err
);

  localparam logic [2:0]  K_LAST   = 3'(FILTER - 1);
  localparam logic [2:0]  FILTER_A = 3'(FILTER);
  localparam logic [4:0]  POS_LAST = 5'(NUM_INPUTS - FILTER);
  localparam int unsigned PAD_W    = PKT_W - OUT_POS_W - PSUM_W;

  state_e                state_q, state_d;
  logic [2:0]            k_q, k_d;
  logic [4:0]            pos_q, pos_d;
  logic [FILTER-1:0]     mask_q, mask_d;
  logic                  ivld_q, ivld_d;
  logic                  w_we_q, w_we_d;
  logic [2:0]            w_waddr_q, w_waddr_d;
  logic [WEIGHT_W-1:0]   w_wdata_q, w_wdata_d;
  logic                  i_we_q, i_we_d;
  logic [NUM_INPUTS-1:0] i_wdata_q, i_wdata_d;
  logic                  err_q, err_d;
  logic                  acc_en_q;
  logic                  acc_clear;
  logic [PSUM_W-1:0]     acc;
  logic [2:0]            wl_addr;

  assign wl_addr = in_data[WL_ADDR_LSB +: WL_ADDR_W];

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    pos_d     = pos_q;
    mask_d    = mask_q;
    ivld_d    = ivld_q;
    w_we_d    = 1'b0;
    w_waddr_d = w_waddr_q;
    w_wdata_d = w_wdata_q;
    i_we_d    = 1'b0;
    i_wdata_d = i_wdata_q;
    err_d     = 1'b0;
    acc_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          case (in_opcode)
            OP_WLOAD: begin
              if (wl_addr < FILTER_A) begin
                w_we_d    = 1'b1;
                w_waddr_d = wl_addr;
                w_wdata_d = in_data[WL_DATA_LSB +: WEIGHT_W];
                for (int unsigned i = 0; i < FILTER; i++) begin
                  if (wl_addr == 3'(i)) mask_d[i] = 1'b1;
                end
              end else begin
                err_d = 1'b1;
              end
            end
            OP_ILOAD: begin
              i_we_d    = 1'b1;
              i_wdata_d = in_data[NUM_INPUTS-1:0];
              ivld_d    = 1'b1;
            end
            OP_START: begin
              if ((&mask_q) && ivld_q) begin
                state_d = StRead;
                pos_d   = '0;
                k_d     = '0;
              end else begin
                err_d = 1'b1;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StRead: begin
        // Nothing is pending in the k = 0 cycle, so clearing here is safe.
        acc_clear = (k_q == 3'd0);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = StDrain;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      StDrain: state_d = StSend;
      StSend: begin
        if (out_ready) begin
          if (pos_q == POS_LAST) begin
            state_d = StIdle;
            pos_d   = '0;
            ivld_d  = 1'b0;
          end else begin
            pos_d   = pos_q + 5'd1;
            state_d = StRead;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      k_q       <= '0;
      pos_q     <= '0;
      mask_q    <= '0;
      ivld_q    <= 1'b0;
      w_we_q    <= 1'b0;
      w_waddr_q <= '0;
      w_wdata_q <= '0;
      i_we_q    <= 1'b0;
      i_wdata_q <= '0;
      err_q     <= 1'b0;
      acc_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      pos_q     <= pos_d;
      mask_q    <= mask_d;
      ivld_q    <= ivld_d;
      w_we_q    <= w_we_d;
      w_waddr_q <= w_waddr_d;
      w_wdata_q <= w_wdata_d;
      i_we_q    <= i_we_d;
      i_wdata_q <= i_wdata_d;
      err_q     <= err_d;
      // RF data returns one cycle after the read address, so accumulate lags by one.
      acc_en_q  <= (state_q == StRead);
    end
  end

  ppe_mac_acc #(
    .WEIGHT_W (WEIGHT_W),
    .PSUM_W   (PSUM_W)
  ) u_mac_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_clear),
    .en     (acc_en_q),
    .spike  (i_rdata),
    .weight (w_rdata),
    .acc    (acc)
  );

  // in_ready is gated by rst so the interface looks quiescent while held in reset.
  assign in_ready   = (state_q == StIdle) && !rst;
  assign busy       = (state_q != StIdle);
  assign w_raddr    = (state_q == StRead) ? k_q : 3'd0;
  assign i_raddr    = (state_q == StRead) ? (pos_q + {2'b00, k_q}) : 5'd0;
  assign out_valid  = (state_q == StSend);
  assign out_opcode = out_valid ? OP_PSUM : 4'h0;
  assign out_data   = out_valid ? {pos_q, {PAD_W{1'b0}}, acc} : '0;
  assign out_dest   = OUT_DEST;
  assign w_we       = w_we_q;
  assign w_waddr    = w_waddr_q;
  assign w_wdata    = w_wdata_q;
  assign i_we       = i_we_q;
  assign i_wdata    = i_wdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ppe_sequencer.sv
// Testbench for ppe_sequencer: models the weight/input RFs, drives command
// packets and checks PSUM packets against hand-computed values.
module tb_ppe_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [24:0] in_data;
  logic        w_we;
  logic [2:0]  w_waddr;
  logic [7:0]  w_wdata;
  logic [2:0]  w_raddr;
  logic [7:0]  w_rdata;
  logic        i_we;
  logic [24:0] i_wdata;
  logic [4:0]  i_raddr;
  logic        i_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_dest;
  logic [3:0]  out_opcode;
  logic [24:0] out_data;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  ppe_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_data    (in_data),
    .w_we       (w_we),
    .w_waddr    (w_waddr),
    .w_wdata    (w_wdata),
    .w_raddr    (w_raddr),
    .w_rdata    (w_rdata),
    .i_we       (i_we),
    .i_wdata    (i_wdata),
    .i_raddr    (i_raddr),
    .i_rdata    (i_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_dest   (out_dest),
    .out_opcode (out_opcode),
    .out_data   (out_data),
    .busy       (busy),
    .err        (err)
  );

  // Register-file models with one-cycle read latency.
  logic [7:0]  wmem [0:7];
  logic [24:0] imem;

  initial begin
    for (int i = 0; i < 8; i++) wmem[i] = 8'd0;
    imem    = 25'd0;
    w_rdata = 8'd0;
    i_rdata = 1'b0;
  end

  always @(posedge clk) begin
    if (w_we) wmem[w_waddr] <= w_wdata;
    if (i_we) imem <= i_wdata;
    w_rdata <= wmem[w_raddr];
    i_rdata <= imem[i_raddr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic send(input logic [3:0] op, input logic [24:0] d);
    @(negedge clk);
    in_valid  = 1'b1;
    in_opcode = op;
    in_data   = d;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_opcode = 4'h0;
    in_data   = 25'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"},  out_valid,  0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_in_ready"},   in_ready,   0);
    check({tag, "_err"},        err,        0);
    check({tag, "_w_we"},       w_we,       0);
    check({tag, "_i_we"},       i_we,       0);
    check({tag, "_w_raddr"},    w_raddr,    0);
    check({tag, "_i_raddr"},    i_raddr,    0);
    check({tag, "_out_data"},   out_data,   0);
    check({tag, "_out_opcode"}, out_opcode, 0);
    check({tag, "_w_waddr"},    w_waddr,    0);
    check({tag, "_w_wdata"},    w_wdata,    0);
    check({tag, "_i_wdata"},    i_wdata,    0);
  endtask

  // Watch a window of cycles in which nothing must start.
  task automatic check_quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    check(name, seen, 0);
  endtask

  logic [10:0] exp_psum [0:20];

  // Collect the 21 packets of one START; packet 0 optionally stalled.
  task automatic collect(input int stall);
    int gap;
    out_ready = (stall == 0);
    for (int p = 0; p < 21; p++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!out_valid && gap < 40);
      check("pkt_valid", out_valid, 1);
      if (!out_valid) return;
      check("pkt_data", out_data, {5'(p), 9'd0, exp_psum[p]});
      check("pkt_dest", out_dest, 4'hA);
      check("pkt_opcode", out_opcode, 4'h4);
      check("pkt_gap", gap, 7);
      check("pkt_in_ready", in_ready, 0);
      if (p == 0 && stall > 0) begin
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, {5'd0, 9'd0, exp_psum[0]});
          check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    check("done_idle", busy, 0);
    check("done_in_ready", in_ready, 1);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [24:0] data;
    logic        exp_err;
    logic        exp_wwe;
    logic        exp_iwe;
  } vec_t;

  vec_t vecs [0:9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int seen;
    int cyc;

    // Weight word = {w, addr}: (w << 3) | addr.
    vecs[0] = '{4'h1, 25'h0008, 1'b0, 1'b1, 1'b0};  // w=1 a=0
    vecs[1] = '{4'h1, 25'h0011, 1'b0, 1'b1, 1'b0};  // w=2 a=1
    vecs[2] = '{4'h1, 25'h001A, 1'b0, 1'b1, 1'b0};  // w=3 a=2
    vecs[3] = '{4'h1, 25'h0023, 1'b0, 1'b1, 1'b0};  // w=4 a=3
    vecs[4] = '{4'h1, 25'h004D, 1'b1, 1'b0, 1'b0};  // a=5 out of range
    vecs[5] = '{4'h1, 25'h004F, 1'b1, 1'b0, 1'b0};  // a=7 out of range
    vecs[6] = '{4'h2, 25'h1FFFFFF, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{4'hF, 25'h0, 1'b1, 1'b0, 1'b0};     // unknown opcode
    vecs[8] = '{4'h0, 25'h0, 1'b1, 1'b0, 1'b0};     // unknown opcode
    vecs[9] = '{4'h3, 25'h0, 1'b1, 1'b0, 1'b0};     // START, weight 4 missing

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_opcode = 4'h0;
    in_data   = 25'd0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);

    // Command decode table.
    for (int i = 0; i < 10; i++) begin
      check("cmd_in_ready", in_ready, 1);
      send(vecs[i].op, vecs[i].data);
      check("cmd_err", err, vecs[i].exp_err);
      check("cmd_w_we", w_we, vecs[i].exp_wwe);
      check("cmd_i_we", i_we, vecs[i].exp_iwe);
      if (vecs[i].exp_wwe) begin
        check("cmd_w_waddr", w_waddr, vecs[i].data[2:0]);
        check("cmd_w_wdata", w_wdata, vecs[i].data[10:3]);
      end
      if (vecs[i].exp_iwe) check("cmd_i_wdata", i_wdata, vecs[i].data);
      @(posedge clk);
      #1;
      check("cmd_pulse_end", {err, w_we, i_we}, 3'b000);
    end
    check_quiet("partial_no_start", 10);

    // Complete the weights (w=5 a=4): every window of all-ones sums to 15.
    send(4'h1, 25'h002C);
    for (int p = 0; p < 21; p++) exp_psum[p] = 11'd15;
    send(4'h3, 25'h0);
    check("start_busy", busy, 1);
    check("start_no_err", err, 0);
    collect(0);

    // Single spike at position 0: only window 0 sees it, through weight 1.
    send(4'h2, 25'h0000001);
    for (int p = 0; p < 21; p++) exp_psum[p] = 11'd0;
    exp_psum[0] = 11'd1;
    send(4'h3, 25'h0);
    collect(0);

    // START after a finished run needs a fresh ILOAD.
    send(4'h3, 25'h0);
    check("start_no_input_err", err, 1);

    // Overwrite every weight with 255; max sum 1275, stalled first packet.
    for (int a = 0; a < 5; a++) send(4'h1, 25'h7F8 | 25'(a));
    send(4'h2, 25'h1FFFFFF);
    for (int p = 0; p < 21; p++) exp_psum[p] = 11'd1275;
    send(4'h3, 25'h0);
    collect(10);

    // Abort with reset during READ of pos 7.
    send(4'h2, 25'h1FFFFFF);
    send(4'h3, 25'h0);
    out_ready = 1'b1;
    seen = 0;
    cyc  = 0;
    while (seen < 7 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid) seen++;
    end
    check("reach_pos7", seen, 7);
    @(negedge clk);
    check("pos7_read_addr", i_raddr, 7);
    check("pos7_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;
    send(4'h2, 25'h1FFFFFF);
    check("abort_iload", i_we, 1);
    send(4'h3, 25'h0);
    check("abort_start_err", err, 1);
    check_quiet("abort_no_start", 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ppe_sequencer.md
Name: ppe_sequencer

Overview:
- Clocked controller that sequences one PPE's weight register file and input register file.
- Accepts configuration and start packets (opcode + 25-bit payload) from the depacketizer side.
- Computes the 1-D spike-gated convolution row (filter length 5 over 25 input spikes) by issuing RF reads and accumulating partial sums.
- Emits one partial-sum packet per output position toward the packetizer.

Parameters:
- NUM_INPUTS, 25, spike positions held in the input RF.
- FILTER, 5, weights per row (weight RF depth used).
- WEIGHT_W, 8, unsigned weight width.
- PSUM_W, 11, unsigned partial-sum width; must be >= WEIGHT_W + clog2(FILTER).
- OUT_DEST, 4'hA, destination address stamped on every output packet.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  inbound packet valid.
- in_ready  out  1  sequencer accepts the inbound packet this cycle.
- in_opcode  in  4  inbound opcode.
- in_data  in  25  inbound payload.
- w_we  out  1  weight RF write strobe.
- w_waddr  out  3  weight RF write address.
- w_wdata  out  8  weight RF write data.
- w_raddr  out  3  weight RF read address.
- w_rdata  in  8  weight RF read data, valid the cycle after w_raddr.
- i_we  out  1  input RF write strobe (whole 25-bit vector).
- i_wdata  out  25  input RF write data.
- i_raddr  out  5  input RF read address.
- i_rdata  in  1  spike bit, valid the cycle after i_raddr.
- out_valid  out  1  outbound packet valid.
- out_ready  in  1  packetizer accepts.
- out_dest  out  4  always OUT_DEST.
- out_opcode  out  4  4'h4 (PSUM).
- out_data  out  25  {pos[4:0], 9'b0, psum[10:0]}.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high, ports clk and rst. Reset forces every output to 0, state to IDLE, weight-valid mask 5'b0, input-valid flag 0, pos 0, k 0, acc 0.
- Handshakes: valid/ready on both sides. A transfer occurs when valid && ready on a rising edge. out_valid, out_data and out_opcode stay stable until accepted.
- Opcodes:
  - 4'h1 WLOAD: w_waddr = data[2:0], w_wdata = data[10:3]. Sets mask bit; addr >= FILTER is dropped with err.
  - 4'h2 ILOAD: i_wdata = data[24:0]; sets the input-valid flag.
  - 4'h3 START: begins compute.
  - Any other opcode is consumed and dropped with err.
- Write timing: w_we or i_we is a single-cycle pulse in the cycle after acceptance.
- States:
  - IDLE: in_ready = 1. WLOAD and ILOAD perform their writes and stay in IDLE. START goes to READ when mask == 5'b11111 and input-valid is set; otherwise err pulses and the state stays IDLE.
  - READ: in_ready = 0. Each cycle drive w_raddr = k and i_raddr = pos + k; k increments 0..4. The state advances to DRAIN after k = 4 is issued.
  - Accumulation: runs one cycle behind the reads. acc += (i_rdata ? w_rdata : 0) in the cycle after each read. acc clears when READ is entered for a new pos.
  - DRAIN: one cycle for the final accumulate, then SEND.
  - SEND: out_valid = 1 until out_ready. On accept: if pos == NUM_INPUTS-FILTER (20), clear input-valid and go to IDLE, keeping weights; else increment pos, reset k, and return to READ.
- Latency: 7 cycles per output with no backpressure (5 READ, 1 DRAIN, 1 SEND). 21 packets per START.
- Arithmetic: unsigned, no saturation. With defaults the maximum is 5*255 = 1275, which fits 11 bits.
- Overwrite: WLOAD to an already-valid address overwrites it; the mask stays set.
- rst asserted mid-compute or mid-SEND aborts immediately. No partial packet is held; out_valid is 0 the next cycle.
- out_ready high while out_valid is low has no effect.

Decomposition:
- Package ppe_pkg holds:
  - Opcode constants: OP_WLOAD = 1, OP_ILOAD = 2, OP_START = 3, OP_PSUM = 4.
  - State enum: IDLE, READ, DRAIN, SEND.
  - Packet field-offset localparams.
- One natural sub-module, ppe_mac_acc: the registered accumulate stage with clear, enable, spike and weight inputs.

Test Plan:
- WLOAD weights 1,2,3,4,5, ILOAD 25'h1FFFFFF, START -> 21 packets, pos 0..20, each psum = 15, out_dest = 4'hA, out_opcode = 4'h4.
- Same weights, ILOAD 25'h0000001 -> pos 0 psum = 1; pos 1..20 psum = 0.
- START with only 4 weights loaded -> err pulses once, no out_valid, busy stays 0.
- Weights all 255, inputs all ones, out_ready held low 10 cycles at the first SEND -> out_valid and out_data ({5'd0, 9'b0, 11'd1275}) stable; in_ready = 0 throughout.
- Assert rst during READ of pos 7 -> next cycle all outputs 0, state IDLE. A following START errs because the mask was cleared.
- Opcode 4'hF while IDLE -> accepted (in_ready = 1), err pulses, no RF write strobe.
